edf_irq_sink: RTL and testbench

Core-side receiver for the EDF interrupt controller's irq_id/irq_valid/irq_ready handshake. It accepts one interrupt ID at a time and presents it to the hart as a trap request. It tracks the in-service ID through to handler completion. With nesting compiled in, it keeps a LIFO of preempted IDs so an earlier-deadline interrupt can preempt a running handler.

---
 rtl/edf_ic_pkg.sv | 17 +
 rtl/edf_id_stack.sv | 55 +++++
 rtl/edf_irq_sink.sv | 131 +++++++++++++
 tb/tb_edf_irq_sink.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/edf_ic_pkg.sv
// Shared types and constants for the EDF interrupt controller and its core-side sink.
package edf_ic_pkg;

    localparam int NrIrqsDefault = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        ACTIVE = 2'd2
    } sink_state_e;

    // ID width for a given number of sources; a single source still needs one bit.
    function automatic int calc_id_width(input int nr_irqs);
        return (nr_irqs > 1) ? $clog2(nr_irqs) : 1;
    endfunction

endpackage

// File: rtl/edf_id_stack.sv
// Small LIFO of interrupt IDs. A push and pop in the same cycle replaces the top entry.
module edf_id_stack
    import edf_ic_pkg::*;
#(
    parameter int Depth = 4,
    parameter int Width = 2,
    localparam int CntWidth = $clog2(Depth + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic                pop_i,
    input  logic [Width-1:0]    data_i,
    output logic [Width-1:0]    top_o,
    output logic [CntWidth-1:0] count_o
);

    logic [Width-1:0]    mem_q [Depth];
    logic [CntWidth-1:0] cnt_q;

    // Stack storage and fill count; popped slots are cleared so an empty stack reads as zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && pop_i && (cnt_q != '0)) begin
            for (int i = 0; i < Depth; i++) begin
                if (i == int'(cnt_q) - 1) mem_q[i] <= data_i;
            end
        end else if (push_i && (int'(cnt_q) < Depth)) begin
            for (int i = 0; i < Depth; i++) begin
                if (i == int'(cnt_q)) mem_q[i] <= data_i;
            end
            cnt_q <= cnt_q + CntWidth'(1);
        end else if (pop_i && (cnt_q != '0)) begin
            for (int i = 0; i < Depth; i++) begin
                if (i == int'(cnt_q) - 1) mem_q[i] <= '0;
            end
            cnt_q <= cnt_q - CntWidth'(1);
        end
    end

    // Top-of-stack read; zero when empty.
    always_comb begin
        top_o = '0;
        for (int i = 0; i < Depth; i++) begin
            if (int'(cnt_q) == i + 1) top_o = mem_q[i];
        end
    end

    assign count_o = cnt_q;

endmodule

// File: rtl/edf_irq_sink.sv
// Core-side receiver for the EDF interrupt controller handshake. Accepts one ID at a
// time, raises a trap request to the hart and tracks the in-service ID until mret.
// Define EDF_SINK_NEST_EN to keep a LIFO of preempted IDs (nesting up to MaxNest);
// without it a single in-service register is used and no preemption is possible.
module edf_irq_sink
    import edf_ic_pkg::*;
#(
    parameter int NrIrqs  = NrIrqsDefault,
    parameter int MaxNest = 4,
    localparam int IdWidth = calc_id_width(NrIrqs),
`ifdef EDF_SINK_NEST_EN
    localparam int MaxNestEff = MaxNest,
`else
    localparam int MaxNestEff = (MaxNest > 1) ? 1 : MaxNest,
`endif
    localparam int DepthWidth = $clog2(MaxNestEff + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [IdWidth-1:0]    irq_id_i,
    input  logic                  irq_valid_i,
    output logic                  irq_ready_o,
    input  logic                  irq_en_i,
    output logic                  irq_req_o,
    output logic [IdWidth-1:0]    irq_req_id_o,
    input  logic                  irq_ack_i,
    input  logic                  irq_done_i,
    output logic                  active_o,
    output logic [IdWidth-1:0]    active_id_o,
    output logic [DepthWidth-1:0] depth_o,
    output logic                  err_o
);

    sink_state_e           state_q, state_d;
    logic [IdWidth-1:0]    pend_id_q, pend_id_d;
    logic                  init_q;
    logic                  err_q, err_d;
    logic [DepthWidth-1:0] depth;
    logic [IdWidth-1:0]    top_id;
    logic                  ready, xfer, push, pop;

    // Handshake qualification: ready only once out of reset, with interrupts enabled and room to nest.
    always_comb begin
        ready = init_q & irq_en_i &
                ((state_q == IDLE) | ((state_q == ACTIVE) & (int'(depth) < MaxNestEff)));
        xfer  = irq_valid_i & ready;
        push  = irq_ack_i & (state_q == PEND);
        pop   = irq_done_i & (depth != '0);
    end

    // Next-state, pending-ID capture and protocol error detection.
    always_comb begin
        state_d   = state_q;
        pend_id_d = pend_id_q;
        err_d     = err_q;
        if (irq_ack_i && (state_q != PEND)) err_d = 1'b1;
        if (irq_done_i && (depth == '0))    err_d = 1'b1;
        if (xfer) pend_id_d = irq_id_i;
        unique case (state_q)
            IDLE:    if (xfer) state_d = PEND;
            PEND:    if (push) state_d = ACTIVE;
            ACTIVE: begin
                if (xfer) begin
                    state_d = PEND;
                end else if (pop && (depth == DepthWidth'(1))) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers; init_q holds ready low for the first cycle after reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pend_id_q <= '0;
            init_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_id_q <= pend_id_d;
            init_q    <= 1'b1;
            err_q     <= err_d;
        end
    end

`ifdef EDF_SINK_NEST_EN
    edf_id_stack #(
        .Depth (MaxNestEff),
        .Width (IdWidth)
    ) u_stack (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (pend_id_q),
        .top_o   (top_id),
        .count_o (depth)
    );
`else
    logic               act_vld_q;
    logic [IdWidth-1:0] act_id_q;

    // Single in-service slot; push and pop cannot coincide because PEND implies an empty slot.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            act_vld_q <= 1'b0;
            act_id_q  <= '0;
        end else if (push) begin
            act_vld_q <= 1'b1;
            act_id_q  <= pend_id_q;
        end else if (pop) begin
            act_vld_q <= 1'b0;
            act_id_q  <= '0;
        end
    end

    assign depth  = DepthWidth'(act_vld_q);
    assign top_id = act_id_q;
`endif

    assign irq_ready_o  = ready;
    assign irq_req_o    = (state_q == PEND);
    assign irq_req_id_o = pend_id_q;
    assign active_o     = (depth != '0);
    assign active_id_o  = top_id;
    assign depth_o      = depth;
    assign err_o        = err_q;

endmodule

// File: tb/tb_edf_irq_sink.sv
// Directed bench for edf_irq_sink: vector table for the basic handshake plus
// hand-written sequences for enable gating, errors, reset and (if compiled) nesting.
module tb_edf_irq_sink;

    localparam int NR  = 4;
    localparam int MN  = 2;
    localparam int IDW = 2;
`ifdef EDF_SINK_NEST_EN
    localparam int DW = $clog2(MN + 1);
`else
    localparam int DW = 1;
`endif

    logic           clk, rst_ni;
    logic [IDW-1:0] irq_id_i;
    logic           irq_valid_i, irq_en_i, irq_ack_i, irq_done_i;
    logic           irq_ready_o, irq_req_o, active_o, err_o;
    logic [IDW-1:0] irq_req_id_o, active_id_o;
    logic [DW-1:0]  depth_o;

    int n_total;
    int n_pass;

    edf_irq_sink #(.NrIrqs(NR), .MaxNest(MN)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .irq_id_i     (irq_id_i),
        .irq_valid_i  (irq_valid_i),
        .irq_ready_o  (irq_ready_o),
        .irq_en_i     (irq_en_i),
        .irq_req_o    (irq_req_o),
        .irq_req_id_o (irq_req_id_o),
        .irq_ack_i    (irq_ack_i),
        .irq_done_i   (irq_done_i),
        .active_o     (active_o),
        .active_id_o  (active_id_o),
        .depth_o      (depth_o),
        .err_o        (err_o)
    );

    typedef struct {
        logic v; logic [1:0] id; logic en; logic ack; logic done;
        logic rdy; logic req; logic [1:0] rid; logic act; logic [1:0] aid; logic [1:0] dep; logic err;
    } vec_t;

    vec_t vecs [12];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int actual, input int expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic chk_out(input string tag, input int rdy, input int req, input int rid,
                           input int act, input int aid, input int dep, input int err);
        chk({tag, ".ready"},     int'(irq_ready_o),  rdy);
        chk({tag, ".req"},       int'(irq_req_o),    req);
        chk({tag, ".req_id"},    int'(irq_req_id_o), rid);
        chk({tag, ".active"},    int'(active_o),     act);
        chk({tag, ".active_id"}, int'(active_id_o),  aid);
        chk({tag, ".depth"},     int'(depth_o),      dep);
        chk({tag, ".err"},       int'(err_o),        err);
    endtask

    task automatic drive(input logic v, input logic [1:0] id, input logic en,
                         input logic ack, input logic done);
        irq_valid_i = v;
        irq_id_i    = id;
        irq_en_i    = en;
        irq_ack_i   = ack;
        irq_done_i  = done;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_ni = 1'b0;
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        #1 chk_out({tag, "_assert"}, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst_ni = 1'b1;
        #1 chk_out({tag, "_release"}, 0, 0, 0, 0, 0, 0, 0);
        step();
        #1 chk_out({tag, "_init"}, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        rst_ni  = 1'b0;
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);

        //               v  id  en ack dn | rdy req rid act aid dep err
        vecs[0]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1, 2'd2, 2'd1, 1'b0};
        vecs[4]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 1'b1, 2'd2, 2'd1, 1'b0};
        vecs[5]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[6]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[7]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0};
        vecs[9]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1, 2'd1, 2'd1, 1'b0};
        vecs[10] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 2'd1, 2'd1, 1'b0};
        vecs[11] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 2'd0, 2'd0, 1'b0};

        @(negedge clk);
        do_reset("t1");

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v, vecs[i].id, vecs[i].en, vecs[i].ack, vecs[i].done);
            #1 chk_out($sformatf("vec%0d", i), int'(vecs[i].rdy), int'(vecs[i].req), int'(vecs[i].rid),
                       int'(vecs[i].act), int'(vecs[i].aid), int'(vecs[i].dep), int'(vecs[i].err));
            step();
        end

        // Enable low blocks the transfer for many cycles; raising it lets it through.
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
            #1 chk("t3_blocked.ready", int'(irq_ready_o), 0);
            chk("t3_blocked.req", int'(irq_req_o), 0);
            step();
        end
        drive(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
        #1 chk("t3_enable.ready", int'(irq_ready_o), 1);
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 chk_out("t3_req", 0, 1, 1, 0, 0, 0, 0);
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 chk_out("t3_active", 0, 0, 1, 1, 1, 1, 0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 chk_out("t3_idle", 0, 0, 1, 0, 0, 0, 0);

        // Ack with nothing pending is a protocol error.
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 chk("ack_idle.err", int'(err_o), 1);

        // Reset while a request is pending discards it.
        drive(1'b1, 2'd2, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        #1 chk_out("mid_pend", 0, 1, 2, 0, 0, 0, 1);
        do_reset("mid");

        // Done in IDLE sets a sticky error that survives normal traffic.
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
        step();
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        #1 chk_out("t6_err", 1, 0, 0, 0, 0, 0, 1);
        drive(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        #1 chk_out("t6_pend", 0, 1, 3, 0, 0, 0, 1);
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        #1 chk_out("t6_active", 0, 0, 3, 1, 3, 1, 1);
        step();
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        #1 chk_out("t6_after", 1, 0, 3, 0, 0, 0, 1);
        do_reset("t6_clr");

`ifdef EDF_SINK_NEST_EN
        // Preemption: ID 3 in service, ID 0 nests on top, then unwinds.
        drive(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 2'd0, 1'b1, 1'b0, 1'b0);
        #1 chk_out("t4_act3", 1, 0, 3, 1, 3, 1, 0);
        step();
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        #1 chk_out("t4_pend0", 0, 1, 0, 1, 3, 1, 0);
        drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
        #1 chk_out("t5_full", 0, 0, 0, 1, 0, 2, 0);
        step();
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
        #1 chk_out("t4_done0", 0, 0, 0, 1, 0, 2, 0);
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 chk_out("t4_pop1", 0, 0, 0, 1, 3, 1, 0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        #1 chk_out("t4_idle", 1, 0, 0, 0, 0, 0, 0);

        // Done and ack together in PEND replace the top entry.
        drive(1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 2'd0, 1'b1, 1'b1, 1'b1);
        #1 chk_out("t5_pre", 0, 1, 1, 1, 3, 1, 0);
        step();
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 chk_out("t5_swap", 0, 0, 1, 1, 1, 1, 0);
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        #1 chk_out("t5_idle", 1, 0, 1, 0, 0, 0, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
